// File: rtl/ru_writeback_if.sv
// Write-back request, memory response and RU write-port bundle.
interface ru_writeback_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  localparam int unsigned OFF_W = $clog2(XLEN / 8);

  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_sel;
  logic                  in_we;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [2:0]            in_funct3;
  logic [OFF_W-1:0]      in_byte_off;
  logic [XLEN-1:0]       alu_result;
  logic [XLEN-1:0]       adder_result;
  logic [XLEN-1:0]       imm_ext;
  logic                  mem_rsp_valid;
  logic [XLEN-1:0]       mem_rsp_data;
  logic                  ru_wr_en;
  logic [REG_ADDR_W-1:0] ru_rd;
  logic [XLEN-1:0]       ru_wrdata;
  logic                  busy;

  modport master (
    output in_valid, in_sel, in_we, in_rd, in_funct3, in_byte_off,
           alu_result, adder_result, imm_ext, mem_rsp_valid, mem_rsp_data,
    input  in_ready, ru_wr_en, ru_rd, ru_wrdata, busy
  );

  modport slave (
    input  in_valid, in_sel, in_we, in_rd, in_funct3, in_byte_off,
           alu_result, adder_result, imm_ext, mem_rsp_valid, mem_rsp_data,
    output in_ready, ru_wr_en, ru_rd, ru_wrdata, busy
  );
endinterface

// File: rtl/ru_writeback_unit.sv
// Registered write-back stage: source mux, load formatting, memory-wait FSM.
module ru_writeback_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  ru_writeback_if.slave wb
);
  localparam int unsigned OFF_W = $clog2(XLEN / 8);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       wrdata_q, wrdata_d;
  logic                  p_we_q, p_we_d;
  logic [REG_ADDR_W-1:0] p_rd_q, p_rd_d;
  logic [2:0]            p_f3_q, p_f3_d;
  logic [OFF_W-1:0]      p_off_q, p_off_d;

  // Extract byte/half/word at the given offset and extend per funct3.
  function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0]  data,
                                                  input logic [2:0]       f3,
                                                  input logic [OFF_W-1:0] off);
    logic [OFF_W-1:0] off_h;
    logic [OFF_W-1:0] off_w;
    logic [7:0]       b8;
    logic [15:0]      h16;
    logic [31:0]      w32;
    off_h = off & ~OFF_W'(1);
    off_w = off & ~OFF_W'(3);
    b8    = 8'(data >> {off, 3'b000});
    h16   = 16'(data >> {off_h, 3'b000});
    w32   = 32'(data >> {off_w, 3'b000});
    case (f3)
      3'b000:  format_load = XLEN'($signed(b8));
      3'b100:  format_load = XLEN'(b8);
      3'b001:  format_load = XLEN'($signed(h16));
      3'b101:  format_load = XLEN'(h16);
      3'b010:  format_load = XLEN'($signed(w32));
      3'b110:  format_load = (XLEN == 64) ? XLEN'(w32) : data;
      default: format_load = data;
    endcase
  endfunction

  // Ready and busy decode directly from the state register.
  assign wb.in_ready  = (state_q == IDLE);
  assign wb.busy      = (state_q == WAIT_MEM);
  assign wb.ru_wr_en  = wr_en_q;
  assign wb.ru_rd     = rd_q;
  assign wb.ru_wrdata = wrdata_q;

  // State, output and pending-load registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_en_q  <= 1'b0;
      rd_q     <= '0;
      wrdata_q <= '0;
      p_we_q   <= 1'b0;
      p_rd_q   <= '0;
      p_f3_q   <= '0;
      p_off_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_en_q  <= wr_en_d;
      rd_q     <= rd_d;
      wrdata_q <= wrdata_d;
      p_we_q   <= p_we_d;
      p_rd_q   <= p_rd_d;
      p_f3_q   <= p_f3_d;
      p_off_q  <= p_off_d;
    end
  end

  // Next-state and next-output logic; outputs hold unless a request completes.
  always_comb begin
    state_d  = state_q;
    wr_en_d  = 1'b0;
    rd_d     = rd_q;
    wrdata_d = wrdata_q;
    p_we_d   = p_we_q;
    p_rd_d   = p_rd_q;
    p_f3_d   = p_f3_q;
    p_off_d  = p_off_q;
    case (state_q)
      IDLE: begin
        if (wb.in_valid) begin
          if (wb.in_sel != SEL_LOAD) begin
            rd_d    = wb.in_rd;
            wr_en_d = wb.in_we && (wb.in_rd != '0);
            case (wb.in_sel)
              SEL_ALU: wrdata_d = wb.alu_result;
              SEL_PC4: wrdata_d = wb.adder_result;
              default: wrdata_d = wb.imm_ext;
            endcase
          end else if (wb.mem_rsp_valid) begin
            rd_d     = wb.in_rd;
            wr_en_d  = wb.in_we && (wb.in_rd != '0);
            wrdata_d = format_load(wb.mem_rsp_data, wb.in_funct3, wb.in_byte_off);
          end else begin
            p_we_d  = wb.in_we;
            p_rd_d  = wb.in_rd;
            p_f3_d  = wb.in_funct3;
            p_off_d = wb.in_byte_off;
            state_d = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (wb.mem_rsp_valid) begin
          rd_d     = p_rd_q;
          wr_en_d  = p_we_q && (p_rd_q != '0);
          wrdata_d = format_load(wb.mem_rsp_data, p_f3_q, p_off_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ru_writeback_unit.sv
// Self-checking bench for ru_writeback_unit: vector table plus corner sequences.
module tb_ru_writeback_unit;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  typedef struct {
    logic [1:0]      sel;
    logic            we;
    logic [RW-1:0]   rd;
    logic [2:0]      f3;
    logic [1:0]      off;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] add;
    logic [XLEN-1:0] imm;
    logic            rsp;
    logic [XLEN-1:0] mem;
    logic            exp_en;
    logic [XLEN-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } exp_t;

  localparam int NV = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  ru_writeback_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();

  ru_writeback_unit #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wb   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] sel, input logic we, input logic [RW-1:0] rd,
                              input logic [2:0] f3, input logic [1:0] off,
                              input logic [XLEN-1:0] alu, input logic [XLEN-1:0] add,
                              input logic [XLEN-1:0] imm, input logic rsp,
                              input logic [XLEN-1:0] mem, input logic en,
                              input logic [XLEN-1:0] data);
    vec_t v;
    v.sel = sel; v.we = we; v.rd = rd; v.f3 = f3; v.off = off;
    v.alu = alu; v.add = add; v.imm = imm; v.rsp = rsp; v.mem = mem;
    v.exp_en = en; v.exp_data = data;
    return v;
  endfunction

  task automatic push_exp(input logic [RW-1:0] rd, input logic [XLEN-1:0] data);
    exp_t e;
    e.rd = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.in_sel = 2'b00; bus.in_we = 1'b0; bus.in_rd = '0;
    bus.in_funct3 = 3'b000; bus.in_byte_off = '0;
    bus.alu_result = '0; bus.adder_result = '0; bus.imm_ext = '0;
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
  endtask

  task automatic drive_req(input logic [1:0] sel, input logic we, input logic [RW-1:0] rd,
                           input logic [2:0] f3, input logic [1:0] off,
                           input logic [XLEN-1:0] alu, input logic [XLEN-1:0] add,
                           input logic [XLEN-1:0] imm, input logic rsp,
                           input logic [XLEN-1:0] mem);
    bus.in_valid = 1'b1; bus.in_sel = sel; bus.in_we = we; bus.in_rd = rd;
    bus.in_funct3 = f3; bus.in_byte_off = off;
    bus.alu_result = alu; bus.adder_result = add; bus.imm_ext = imm;
    bus.mem_rsp_valid = rsp; bus.mem_rsp_data = mem;
  endtask

  // Every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.ru_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got ru_wr_en=1 rd=%0d data=0x%0h expected no write",
                 bus.ru_rd, bus.ru_wrdata);
      end else begin
        mon_e = sb.pop_front();
        check("sb_rd", 64'(bus.ru_rd), 64'(mon_e.rd));
        check("sb_data", 64'(bus.ru_wrdata), 64'(mon_e.data));
      end
    end
  end

  initial begin
    vecs[0]  = mk(2'b00, 1, 5'd5,  3'b111, 2'd0, 32'h0000_1234, 32'h2222_2222, 32'h3333_3333, 1, 32'hFFFF_FFFF, 1, 32'h0000_1234);
    vecs[1]  = mk(2'b01, 1, 5'd6,  3'b000, 2'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 32'h80FF_0000, 1, 32'hFFFF_FF80);
    vecs[2]  = mk(2'b01, 1, 5'd7,  3'b100, 2'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 32'h80FF_0000, 1, 32'h0000_0080);
    vecs[3]  = mk(2'b01, 1, 5'd8,  3'b000, 2'd2, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 32'h80FF_0000, 1, 32'hFFFF_FFFF);
    vecs[4]  = mk(2'b01, 1, 5'd9,  3'b100, 2'd1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 32'h80FF_0000, 1, 32'h0000_0000);
    vecs[5]  = mk(2'b01, 1, 5'd10, 3'b001, 2'd2, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 32'h80FF_0000, 1, 32'hFFFF_80FF);
    vecs[6]  = mk(2'b01, 1, 5'd11, 3'b001, 2'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 32'h80FF_0000, 1, 32'hFFFF_80FF);
    vecs[7]  = mk(2'b01, 1, 5'd12, 3'b101, 2'd2, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 32'h80FF_0000, 1, 32'h0000_80FF);
    vecs[8]  = mk(2'b01, 1, 5'd13, 3'b010, 2'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 32'h80FF_0000, 1, 32'h80FF_0000);
    vecs[9]  = mk(2'b01, 1, 5'd14, 3'b000, 2'd0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 32'h1234_7F56, 1, 32'h0000_0056);
    vecs[10] = mk(2'b01, 1, 5'd15, 3'b001, 2'd0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 32'h1234_7F56, 1, 32'h0000_7F56);
    vecs[11] = mk(2'b01, 1, 5'd16, 3'b101, 2'd2, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 32'h1234_7F56, 1, 32'h0000_1234);
    vecs[12] = mk(2'b01, 1, 5'd17, 3'b011, 2'd1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 32'h1234_7F56, 1, 32'h1234_7F56);
    vecs[13] = mk(2'b01, 1, 5'd18, 3'b110, 2'd2, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 32'h1234_7F56, 1, 32'h1234_7F56);
    vecs[14] = mk(2'b10, 1, 5'd1,  3'b000, 2'd0, 32'h1111_1111, 32'h0000_0104, 32'h3333_3333, 0, 32'h0,          1, 32'h0000_0104);
    vecs[15] = mk(2'b11, 1, 5'd0,  3'b000, 2'd0, 32'h1111_1111, 32'h2222_2222, 32'hDEAD_B000, 0, 32'h0,          0, 32'hDEAD_B000);
    vecs[16] = mk(2'b11, 1, 5'd20, 3'b000, 2'd0, 32'h1111_1111, 32'h2222_2222, 32'h1234_5000, 0, 32'h0,          1, 32'h1234_5000);
    vecs[17] = mk(2'b00, 0, 5'd3,  3'b000, 2'd0, 32'h0000_CAFE, 32'h2222_2222, 32'h3333_3333, 0, 32'h0,          0, 32'h0000_CAFE);
    vecs[18] = mk(2'b01, 1, 5'd0,  3'b000, 2'd0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1, 32'h0000_00FF, 0, 32'hFFFF_FFFF);

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", 64'(bus.ru_wr_en), 64'd0);
    check("rst_rd", 64'(bus.ru_rd), 64'd0);
    check("rst_wrdata", 64'(bus.ru_wrdata), 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;

    // Single-cycle requests from the table.
    for (int i = 0; i < NV; i++) begin
      check("vec_ready", 64'(bus.in_ready), 64'd1);
      drive_req(vecs[i].sel, vecs[i].we, vecs[i].rd, vecs[i].f3, vecs[i].off,
                vecs[i].alu, vecs[i].add, vecs[i].imm, vecs[i].rsp, vecs[i].mem);
      if (vecs[i].exp_en) push_exp(vecs[i].rd, vecs[i].exp_data);
      @(posedge clk);
      #1 idle_inputs();
      @(negedge clk);
      check($sformatf("vec%0d_wr_en", i), 64'(bus.ru_wr_en), 64'(vecs[i].exp_en));
      check($sformatf("vec%0d_wrdata", i), 64'(bus.ru_wrdata), 64'(vecs[i].exp_data));
      if (vecs[i].exp_en) check($sformatf("vec%0d_rd", i), 64'(bus.ru_rd), 64'(vecs[i].rd));
    end

    // A stray memory response in IDLE without a load changes nothing.
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 32'h7777_7777;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("stray_rsp_wr_en", 64'(bus.ru_wr_en), 64'd0);
    check("stray_rsp_wrdata", 64'(bus.ru_wrdata), 64'hFFFF_FFFF);

    // LH with a 3-cycle memory wait; an ALU request waits and lands in the pulse cycle.
    drive_req(2'b01, 1, 5'd9, 3'b001, 2'd2, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1 drive_req(2'b00, 1, 5'd4, 3'b100, 2'd0, 32'hA5A5_0004, 32'h0, 32'h0, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("wait%0d_busy", k), 64'(bus.busy), 64'd1);
      check($sformatf("wait%0d_ready", k), 64'(bus.in_ready), 64'd0);
      check($sformatf("wait%0d_wr_en", k), 64'(bus.ru_wr_en), 64'd0);
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 32'h8001_5A5A;
    push_exp(5'd9, 32'hFFFF_8001);
    @(posedge clk);
    #1 bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("lh_pulse_wr_en", 64'(bus.ru_wr_en), 64'd1);
    check("lh_pulse_ready", 64'(bus.in_ready), 64'd1);
    check("lh_pulse_busy", 64'(bus.busy), 64'd0);
    push_exp(5'd4, 32'hA5A5_0004);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("alu_after_lh_wrdata", 64'(bus.ru_wrdata), 64'hA5A5_0004);

    // Reset while a load is outstanding drops it.
    drive_req(2'b01, 1, 5'd12, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 32'h0000_00AB;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("mid_rst_wr_en", 64'(bus.ru_wr_en), 64'd0);
    check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_rd", 64'(bus.ru_rd), 64'd0);
    check("mid_rst_wrdata", 64'(bus.ru_wrdata), 64'd0);

    // Back-to-back PC+4 requests give consecutive pulses in order.
    drive_req(2'b10, 1, 5'd1, 3'b000, 2'd0, 32'h0, 32'h0000_0104, 32'h0, 0, 32'h0);
    push_exp(5'd1, 32'h0000_0104);
    @(negedge clk);
    check("b2b_pulse0", 64'(bus.ru_wr_en), 64'd1);
    drive_req(2'b10, 1, 5'd2, 3'b000, 2'd0, 32'h0, 32'h0000_0108, 32'h0, 0, 32'h0);
    push_exp(5'd2, 32'h0000_0108);
    @(negedge clk);
    check("b2b_pulse1", 64'(bus.ru_wr_en), 64'd1);
    drive_req(2'b10, 1, 5'd3, 3'b000, 2'd0, 32'h0, 32'h0000_010C, 32'h0, 0, 32'h0);
    push_exp(5'd3, 32'h0000_010C);
    @(negedge clk);
    check("b2b_pulse2", 64'(bus.ru_wr_en), 64'd1);
    idle_inputs();
    @(negedge clk);
    check("b2b_end", 64'(bus.ru_wr_en), 64'd0);
    check("b2b_last_data", 64'(bus.ru_wrdata), 64'h0000_010C);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
